// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Parametrised, handshaked pipeline-stage register with a one-entry skid
// buffer. It carries an instruction, a PC and an opaque payload. It replaces
// the fixed-field, enable-gated D/E/M/W stage registers of the five-stage
// MIPS core.
//
// in_ready depends only on registered state and flush. It never depends on
// out_ready, so upstream ready is never combinationally coupled to
// downstream ready.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   flush      in   synchronous discard of all held entries (NOP bubble)
//   in_valid   in   upstream presents an entry
//   in_ready   out  stage can accept (~skid_valid & ~flush)
//   in_instr   in   upstream instruction   [INSTR_W]
//   in_pc      in   upstream PC            [PC_W]
//   in_data    in   upstream payload       [DATA_W]
//   out_valid  out  main entry valid (registered)
//   out_ready  in   downstream consumes the main entry
//   out_instr  out  main instruction, NOP_INSTR when out_valid=0
//   out_pc     out  main PC
//   out_data   out  main payload
//   occupancy  out  number of held entries 0..2 (registered)
module pipe_stage_reg #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter int                 DATA_W    = 97,
    parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_3000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [INSTR_W-1:0]  main_instr_r;
    logic [PC_W-1:0]     main_pc_r;
    logic [DATA_W-1:0]   main_data_r;
    logic [INSTR_W-1:0]  skid_instr_r;
    logic [PC_W-1:0]     skid_pc_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic                out_valid_r;
    logic                skid_valid_r;
    logic [1:0]          occupancy_r;

    logic [INSTR_W-1:0]  main_instr_nxt_s;
    logic [PC_W-1:0]     main_pc_nxt_s;
    logic [DATA_W-1:0]   main_data_nxt_s;
    logic [INSTR_W-1:0]  skid_instr_nxt_s;
    logic [PC_W-1:0]     skid_pc_nxt_s;
    logic [DATA_W-1:0]   skid_data_nxt_s;
    logic                out_valid_nxt_s;
    logic                skid_valid_nxt_s;
    logic [1:0]          occupancy_nxt_s;

    logic                in_ready_s;
    logic                accept_s;
    logic                drain_s;

    // Handshake qualifiers. skid_valid_r is registered, so in_ready has no
    // path from out_ready.
    always_comb begin
        in_ready_s = ~skid_valid_r & ~flush;
        accept_s   = in_valid & in_ready_s;
        drain_s    = out_valid_r & out_ready;
    end

    // Next-state and next-entry selection for the EMPTY/ONE/TWO machine.
    always_comb begin
        state_nxt_s      = state_r;
        main_instr_nxt_s = main_instr_r;
        main_pc_nxt_s    = main_pc_r;
        main_data_nxt_s  = main_data_r;
        skid_instr_nxt_s = skid_instr_r;
        skid_pc_nxt_s    = skid_pc_r;
        skid_data_nxt_s  = skid_data_r;

        case (state_r)
            ST_EMPTY: begin
                // out_ready is irrelevant here: nothing to drain.
                if (accept_s) begin
                    state_nxt_s      = ST_ONE;
                    main_instr_nxt_s = in_instr;
                    main_pc_nxt_s    = in_pc;
                    main_data_nxt_s  = in_data;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    state_nxt_s      = ST_ONE;
                    main_instr_nxt_s = in_instr;
                    main_pc_nxt_s    = in_pc;
                    main_data_nxt_s  = in_data;
                end else if (accept_s) begin
                    // Downstream stalled: park the new entry behind main.
                    state_nxt_s      = ST_TWO;
                    skid_instr_nxt_s = in_instr;
                    skid_pc_nxt_s    = in_pc;
                    skid_data_nxt_s  = in_data;
                end else if (drain_s) begin
                    // Going empty: present a NOP, keep pc/data stable.
                    state_nxt_s      = ST_EMPTY;
                    main_instr_nxt_s = NOP_INSTR;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_TWO: begin
                // in_ready is low in TWO, so only a drain can move us.
                if (drain_s) begin
                    state_nxt_s      = ST_ONE;
                    main_instr_nxt_s = skid_instr_r;
                    main_pc_nxt_s    = skid_pc_r;
                    main_data_nxt_s  = skid_data_r;
                    skid_instr_nxt_s = NOP_INSTR;
                end else begin
                    state_nxt_s = ST_TWO;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean empty stage.
                state_nxt_s      = ST_EMPTY;
                main_instr_nxt_s = NOP_INSTR;
                skid_instr_nxt_s = NOP_INSTR;
            end
        endcase

        // Flush overrides everything. A drain this cycle still reaches
        // downstream; only the stage's copies are discarded. pc/data hold
        // their current register contents.
        if (flush) begin
            state_nxt_s      = ST_EMPTY;
            main_instr_nxt_s = NOP_INSTR;
            main_pc_nxt_s    = main_pc_r;
            main_data_nxt_s  = main_data_r;
            skid_instr_nxt_s = NOP_INSTR;
            skid_pc_nxt_s    = skid_pc_r;
            skid_data_nxt_s  = skid_data_r;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Status flags derived from the next state. They are registered
    // alongside the state so that out_valid and occupancy are flop outputs.
    always_comb begin
        out_valid_nxt_s  = 1'b0;
        skid_valid_nxt_s = 1'b0;
        occupancy_nxt_s  = 2'd0;
        case (state_nxt_s)
            ST_EMPTY: begin
                out_valid_nxt_s  = 1'b0;
                skid_valid_nxt_s = 1'b0;
                occupancy_nxt_s  = 2'd0;
            end
            ST_ONE: begin
                out_valid_nxt_s  = 1'b1;
                skid_valid_nxt_s = 1'b0;
                occupancy_nxt_s  = 2'd1;
            end
            ST_TWO: begin
                out_valid_nxt_s  = 1'b1;
                skid_valid_nxt_s = 1'b1;
                occupancy_nxt_s  = 2'd2;
            end
            default: begin
                out_valid_nxt_s  = 1'b0;
                skid_valid_nxt_s = 1'b0;
                occupancy_nxt_s  = 2'd0;
            end
        endcase
    end

    // State, status and entry registers. Payloads are reset too, so no X
    // ever reaches the outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_EMPTY;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            occupancy_r  <= 2'd0;
            main_instr_r <= NOP_INSTR;
            main_pc_r    <= RESET_PC;
            main_data_r  <= {DATA_W{1'b0}};
            skid_instr_r <= NOP_INSTR;
            skid_pc_r    <= RESET_PC;
            skid_data_r  <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            occupancy_r  <= occupancy_nxt_s;
            main_instr_r <= main_instr_nxt_s;
            main_pc_r    <= main_pc_nxt_s;
            main_data_r  <= main_data_nxt_s;
            skid_instr_r <= skid_instr_nxt_s;
            skid_pc_r    <= skid_pc_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_instr = main_instr_r;
    assign out_pc    = main_pc_r;
    assign out_data  = main_data_r;
    assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [96:0] in_data;

    // Default-parameter instance.
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_instr, a_out_pc;
    logic [96:0] a_out_data;
    logic [1:0]  a_occ;

    // Narrow instance: INSTR_W=16, DATA_W=1, RESET_PC=0, sharing the same stimulus.
    logic        b_in_ready, b_out_valid;
    logic [15:0] b_out_instr;
    logic [31:0] b_out_pc;
    logic [0:0]  b_out_data;
    logic [1:0]  b_occ;

    pipe_stage_reg dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_instr(a_out_instr), .out_pc(a_out_pc), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_reg #(
        .INSTR_W(16), .PC_W(32), .DATA_W(1),
        .RESET_PC(32'h0000_0000), .NOP_INSTR(16'h0000)
    ) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr[15:0]), .in_pc(in_pc), .in_data(in_data[0:0]),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_instr(b_out_instr), .out_pc(b_out_pc), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    // Behavioural model: a FIFO of at most two entries, plus the entry most
    // recently at its head. That head entry supplies pc/data while the stage is empty.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [96:0] data;
    } ent_t;

    ent_t q[$];
    ent_t ghost_a, ghost_b;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ghost_a = '{instr: 32'h0, pc: 32'h0000_3000, data: 97'h0};
        ghost_b = '{instr: 32'h0, pc: 32'h0000_0000, data: 97'h0};
    endtask

    task automatic check_outputs();
        bit ne;
        ne = (q.size() > 0);
        chk("a_valid", a_out_valid, ne);
        chk("a_occ",   a_occ, q.size());
        chk("a_instr", a_out_instr, ne ? q[0].instr : 32'h0);
        chk("a_pc",    a_out_pc,    ne ? q[0].pc    : ghost_a.pc);
        chk("a_data",  a_out_data,  ne ? q[0].data  : ghost_a.data);
        chk("b_valid", b_out_valid, ne);
        chk("b_occ",   b_occ, q.size());
        chk("b_instr", b_out_instr, ne ? q[0].instr[15:0] : 16'h0);
        chk("b_pc",    b_out_pc,    ne ? q[0].pc    : ghost_b.pc);
        chk("b_data",  b_out_data,  ne ? q[0].data[0] : ghost_b.data[0]);
    endtask

    // One clock cycle. Inputs are already driven. Check in_ready at the negedge,
    // advance the model at the posedge, then compare the registered outputs.
    task automatic cycle();
        bit acc, drn, rdy;
        ent_t e;
        @(negedge clk);
        rdy = (q.size() < 2) && !flush;
        chk("a_in_ready", a_in_ready, rdy);
        chk("b_in_ready", b_in_ready, rdy);
        acc = in_valid && rdy;
        drn = (q.size() > 0) && out_ready;
        e = '{instr: in_instr, pc: in_pc, data: in_data};
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (q.size() > 0) begin
            ghost_a = q[0];
            ghost_b = q[0];
        end
        #1;
        check_outputs();
    endtask

    task automatic offer(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [96:0] data);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
        in_data  = data;
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0; in_data = 97'h0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_a_valid", a_out_valid, 1'b0);
        chk("rst_a_pc",    a_out_pc, 32'h0000_3000);
        chk("rst_a_occ",   a_occ, 2'd0);
        chk("rst_b_pc",    b_out_pc, 32'h0000_0000);
        repeat (3) cycle();
        reset = 1'b1;
        #1;
        chk("rst_in_ready", a_in_ready, 1'b1);

        // Pass-through.
        out_ready = 1'b1;
        offer(1'b1, 32'h2402_0005, 32'h0000_3000, 97'h1_0000_0005);
        cycle();
        chk("pt_valid", a_out_valid, 1'b1);
        chk("pt_pc0",   a_out_pc, 32'h0000_3000);
        chk("pt_data0", a_out_data, 97'h1_0000_0005);
        offer(1'b1, 32'h2402_0006, 32'h0000_3004, 97'h6);
        cycle();
        chk("pt_pc1", a_out_pc, 32'h0000_3004);
        chk("pt_occ", a_occ, 2'd1);
        chk("pt_b_instr", b_out_instr, 16'h0006);
        offer(1'b0, 32'h0, 32'h0, 97'h0);
        cycle();

        // Back-pressure fill: the third entry is held upstream until the skid entry drains.
        out_ready = 1'b0;
        offer(1'b1, 32'h1111_0000, 32'h0000_3000, 97'h10);
        cycle();
        offer(1'b1, 32'h1111_0004, 32'h0000_3004, 97'h14);
        cycle();
        chk("bp_occ2", a_occ, 2'd2);
        offer(1'b1, 32'h1111_0008, 32'h0000_3008, 97'h18);
        #1 chk("bp_in_ready", a_in_ready, 1'b0);
        cycle();
        chk("bp_hold_pc", a_out_pc, 32'h0000_3000);
        out_ready = 1'b1;
        cycle();
        chk("bp_pc1", a_out_pc, 32'h0000_3004);
        cycle();
        chk("bp_pc2", a_out_pc, 32'h0000_3008);
        offer(1'b0, 32'h0, 32'h0, 97'h0);
        cycle();
        chk("bp_empty", a_occ, 2'd0);

        // Drain to empty.
        offer(1'b1, 32'h2222_0010, 32'h0000_3010, 97'h20);
        cycle();
        offer(1'b0, 32'h0, 32'h0, 97'h0);
        cycle();
        chk("dr_valid", a_out_valid, 1'b0);
        chk("dr_instr", a_out_instr, 32'h0000_0000);
        chk("dr_occ",   a_occ, 2'd0);
        chk("dr_pc",    a_out_pc, 32'h0000_3010);

        // Flush in TWO while an entry is offered.
        out_ready = 1'b0;
        offer(1'b1, 32'h3333_0020, 32'h0000_3020, 97'h30);
        cycle();
        offer(1'b1, 32'h3333_0024, 32'h0000_3024, 97'h34);
        cycle();
        flush = 1'b1;
        offer(1'b1, 32'h3333_0028, 32'h0000_3028, 97'h38);
        #1 chk("fl_in_ready", a_in_ready, 1'b0);
        cycle();
        chk("fl_occ",   a_occ, 2'd0);
        chk("fl_valid", a_out_valid, 1'b0);
        chk("fl_instr", a_out_instr, 32'h0000_0000);
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 97'h0);
        cycle();
        chk("fl_not_captured", a_occ, 2'd0);

        // Asynchronous reset between edges while in TWO.
        offer(1'b1, 32'h4444_0030, 32'h0000_3030, 97'h40);
        cycle();
        offer(1'b1, 32'h4444_0034, 32'h0000_3034, 97'h44);
        cycle();
        chk("ar_occ2", a_occ, 2'd2);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", a_out_valid, 1'b0);
        chk("ar_pc",    a_out_pc, 32'h0000_3000);
        chk("ar_occ",   a_occ, 2'd0);
        chk("ar_b_pc",  b_out_pc, 32'h0000_0000);
        model_reset();
        offer(1'b0, 32'h0, 32'h0, 97'h0);
        repeat (2) cycle();
        reset = 1'b1;

        // Randomised traffic checked against the model every cycle.
        for (int i = 0; i < 600; i++) begin
            offer($urandom_range(0, 3) != 0, $urandom, 32'h0000_3000 + (i << 2),
                  {$urandom_range(0, 1), $urandom, $urandom, $urandom});
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline-stage register; successor to the fixed-field enable-gated stage registers (D/E/M/W) in the five-stage MIPS core.
- Carries instruction, PC and an opaque payload bus.
- Adds valid/ready flow control, a one-entry skid buffer so a stage register never combinationally couples upstream ready to downstream ready, and synchronous flush with NOP-bubble insertion.

Parameters:
- INSTR_W, 32, instruction field width
- PC_W, 32, PC field width
- DATA_W, 97, payload width (e.g. ALUOut 32 + rtOut 32 + EXTOut 32 + CMP 1)
- RESET_PC, 32'h0000_3000, PC value loaded into both entries on reset
- NOP_INSTR, 32'h0000_0000, instruction value presented when the stage holds no valid entry

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  upstream presents an entry
- in_ready  out  1  stage can accept; in_ready = ~skid_valid & ~flush
- in_instr  in  INSTR_W  upstream instruction
- in_pc  in  PC_W  upstream PC
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream consumes main entry
- out_instr  out  INSTR_W  main instruction (NOP_INSTR when out_valid=0)
- out_pc  out  PC_W  main PC
- out_data  out  DATA_W  main payload
- occupancy  out  2  held entries: 0, 1 or 2

Behaviour:
- Reset (reset=0, asynchronous):
  - state EMPTY; main and skid instr=NOP_INSTR, pc=RESET_PC, data=0.
  - out_valid=0, occupancy=0, in_ready=1 once reset=1 and flush=0.
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready. All updates on the rising edge of clk.
- State machine, EMPTY / ONE / TWO; out_valid = (state!=EMPTY); skid_valid = (state==TWO):
  - EMPTY: accept -> ONE, main<=in. Otherwise hold. out_ready is ignored.
  - ONE:
    - accept&drain -> ONE, main<=in.
    - accept&~drain -> TWO, skid<=in, main held.
    - ~accept&drain -> EMPTY, main instr<=NOP_INSTR, pc/data hold.
    - neither -> hold.
  - TWO: in_ready=0, so accept is impossible. drain -> ONE, main<=skid, skid instr<=NOP_INSTR. Otherwise hold.
- Latency: 1 cycle from accept in EMPTY/ONE to out_valid; no combinational path from in_* to out_*.
- Ordering: strict FIFO; the skid entry is never presented ahead of main.
- in_ready is a function of registered state and flush only; no dependence on out_ready.
- Flush (flush=1, reset=1):
  - in_ready forced 0, so the same-cycle input is never accepted.
  - Next state EMPTY, both instr<=NOP_INSTR, pc/data hold.
  - A drain in the flush cycle still completes downstream; only the stage copy is discarded.
- Stall semantics: holding out_ready=0 reproduces enable-gated register behaviour: the stage fills to TWO and back-pressures upstream.
- Reset asserted mid-transfer: all state cleared immediately, regardless of clk. Deassertion is synchronised externally; the block does not re-time it.
- occupancy = 0/1/2 for EMPTY/ONE/TWO, registered.
- No X propagation: payload registers are reset even though only instr is semantically checked when invalid.

Test Plan:
- Reset then pass-through:
  - Stimulus: reset low 3 cycles, release; out_ready=1; in_valid=1 with instr 0x24020005, pc 0x3000, data 0x1_0000_0005; then pc 0x3004.
  - Required: out_valid rises one cycle after the first accept with out_pc=0x3000, then 0x3004 the next cycle; occupancy stays 1; in_ready=1 throughout.
- Back-pressure fill:
  - Stimulus: out_ready=0; offer three entries (pc 0x3000/0x3004/0x3008).
  - Required: first two accepted; occupancy=2; in_ready=0; the third is held upstream.
  - Then out_ready=1: outputs appear in order 0x3000, 0x3004, 0x3008, one per cycle, and no entry is lost.
- Drain to empty:
  - Stimulus: one entry at pc 0x3010, then in_valid=0, out_ready=1.
  - Required: after the drain, out_valid=0, out_instr=0x00000000, occupancy=0.
- Flush in TWO with simultaneous in_valid:
  - Stimulus: flush=1 for one cycle while the stage is in TWO and in_valid=1.
  - Required: in_ready=0 that cycle; the next cycle has occupancy=0, out_valid=0, out_instr=NOP; the offered entry is not captured.
- Asynchronous reset mid-stream:
  - Stimulus: drop reset between clock edges while in TWO.
  - Required: out_valid=0, out_pc=0x3000 and occupancy=0 immediately, before the next clk edge.
- Parameter sweep:
  - Stimulus: DATA_W=1, INSTR_W=16, RESET_PC=0; repeat scenarios 1–4.
  - Required: identical handshake behaviour and correct field widths.
